// File: rtl/add16u_err_monitor_if.sv
// Sample/control/statistics bundle between the approximate-adder stream
// source (master) and the error monitor (slave).
interface add16u_err_monitor_if #(
   parameter int unsigned W     = 16,
   parameter int unsigned CNT_W = 32,
   parameter int unsigned ACC_W = 48
);
   // Run control
   logic             clr;
   logic             run;
   logic [CNT_W-1:0] n_samples;

   // Sample stream
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic [W:0]       o;

   // Status and statistics
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] sample_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [ACC_W-1:0] err_sum;
   logic [W:0]       wce;
   logic [W-1:0]     wce_a;
   logic [W-1:0]     wce_b;

   modport master (
      output clr, run, n_samples, in_valid, a, b, o,
      input  in_ready, busy, done, sample_cnt, err_cnt, err_sum, wce, wce_a, wce_b
   );

   modport slave (
      input  clr, run, n_samples, in_valid, a, b, o,
      output in_ready, busy, done, sample_cnt, err_cnt, err_sum, wce, wce_a, wce_b
   );
endinterface

// File: rtl/add16u_err_monitor.sv
// Error-statistics monitor for 16-bit unsigned approximate adders.
// Takes (A, B, O) triples, forms the exact sum, and accumulates sample count,
// error count, sum of |error| and worst-case error with its operands.
module add16u_err_monitor #(
   parameter int unsigned W     = 16,
   parameter int unsigned CNT_W = 32,
   parameter int unsigned ACC_W = 48
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   add16u_err_monitor_if.slave  io_mon
);

   localparam int unsigned SUM_W = ACC_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Control state
   state_t           r_state;
   logic [CNT_W-1:0] r_n;
   logic [CNT_W-1:0] r_acc_cnt;
   logic             r_in_ready;
   logic             r_busy;
   logic             r_done;

   // Pipeline stage 1: operands, approximate result, exact sum
   logic             r_s1_v;
   logic [W-1:0]     r_s1_a;
   logic [W-1:0]     r_s1_b;
   logic [W:0]       r_s1_o;
   logic [W:0]       r_s1_exact;

   // Pipeline stage 2: absolute error with its operands
   logic             r_s2_v;
   logic [W-1:0]     r_s2_a;
   logic [W-1:0]     r_s2_b;
   logic [W:0]       r_s2_err;

   // Statistics
   logic [CNT_W-1:0] r_sample_cnt;
   logic [CNT_W-1:0] r_err_cnt;
   logic [ACC_W-1:0] r_err_sum;
   logic [W:0]       r_wce;
   logic [W-1:0]     r_wce_a;
   logic [W-1:0]     r_wce_b;

   logic             w_start;
   logic             w_accept;
   logic [CNT_W-1:0] w_acc_inc;
   logic             w_pipe_empty;
   logic signed [W+1:0] w_diff;
   logic signed [W+1:0] w_abs;
   logic [W:0]       w_err;
   logic [SUM_W-1:0] w_sum_ext;
   logic [ACC_W-1:0] w_err_sum_nxt;

   // A run starts from IDLE or DONE; CLR overrides a simultaneous RUN
   assign w_start      = io_mon.run & ~io_mon.clr &
                         ((r_state == S_IDLE) | (r_state == S_DONE));
   assign w_accept     = io_mon.in_valid & r_in_ready;
   assign w_acc_inc    = r_acc_cnt + CNT_W'(1);
   assign w_pipe_empty = ~r_s1_v & ~r_s2_v;

   // |exact - O| in W+2-bit signed arithmetic; the magnitude always fits W+1 bits
   assign w_diff = $signed({1'b0, r_s1_exact}) - $signed({1'b0, r_s1_o});
   assign w_abs  = (w_diff < 0) ? -w_diff : w_diff;
   assign w_err  = w_abs[W:0];

   // Saturating accumulation of |error|
   assign w_sum_ext     = {1'b0, r_err_sum} + SUM_W'(r_s2_err);
   assign w_err_sum_nxt = w_sum_ext[ACC_W] ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];

   // Run-control FSM with registered IN_READY/BUSY/DONE
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_n        <= '0;
         r_acc_cnt  <= '0;
         r_in_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else if (io_mon.clr) begin
         r_state    <= S_IDLE;
         r_n        <= '0;
         r_acc_cnt  <= '0;
         r_in_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else if (w_start) begin
         r_state    <= S_RUN;
         r_n        <= io_mon.n_samples;
         r_acc_cnt  <= '0;
         r_in_ready <= (io_mon.n_samples != '0);
         r_busy     <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
            end
            S_RUN: begin
               if (r_acc_cnt >= r_n) begin
                  // Only reachable for N=0: nothing to accept
                  r_state    <= S_DRAIN;
                  r_in_ready <= 1'b0;
               end else if (w_accept) begin
                  r_acc_cnt <= w_acc_inc;
                  if (w_acc_inc >= r_n) begin
                     r_state    <= S_DRAIN;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            S_DRAIN: begin
               r_in_ready <= 1'b0;
               if (w_pipe_empty) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
               r_done     <= 1'b1;
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
            end
         endcase
      end
   end

   // Two-stage compute pipeline; CLR drops whatever is in flight
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1_v     <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_o     <= '0;
         r_s1_exact <= '0;
         r_s2_v     <= 1'b0;
         r_s2_a     <= '0;
         r_s2_b     <= '0;
         r_s2_err   <= '0;
      end else if (io_mon.clr) begin
         r_s1_v <= 1'b0;
         r_s2_v <= 1'b0;
      end else begin
         r_s1_v <= w_accept;
         if (w_accept) begin
            r_s1_a     <= io_mon.a;
            r_s1_b     <= io_mon.b;
            r_s1_o     <= io_mon.o;
            r_s1_exact <= {1'b0, io_mon.a} + {1'b0, io_mon.b};
         end
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_s2_a   <= r_s1_a;
            r_s2_b   <= r_s1_b;
            r_s2_err <= w_err;
         end
      end
   end

   // Statistics: cleared on start/CLR, updated from a valid stage-2 sample
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sample_cnt <= '0;
         r_err_cnt    <= '0;
         r_err_sum    <= '0;
         r_wce        <= '0;
         r_wce_a      <= '0;
         r_wce_b      <= '0;
      end else if (io_mon.clr || w_start) begin
         r_sample_cnt <= '0;
         r_err_cnt    <= '0;
         r_err_sum    <= '0;
         r_wce        <= '0;
         r_wce_a      <= '0;
         r_wce_b      <= '0;
      end else if (r_s2_v) begin
         if (r_sample_cnt != {CNT_W{1'b1}}) begin
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
         end
         if ((r_s2_err != '0) && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
         end
         r_err_sum <= w_err_sum_nxt;
         // Strictly greater: ties keep the earlier sample's operands
         if (r_s2_err > r_wce) begin
            r_wce   <= r_s2_err;
            r_wce_a <= r_s2_a;
            r_wce_b <= r_s2_b;
         end
      end
   end

   assign io_mon.in_ready   = r_in_ready;
   assign io_mon.busy       = r_busy;
   assign io_mon.done       = r_done;
   assign io_mon.sample_cnt = r_sample_cnt;
   assign io_mon.err_cnt    = r_err_cnt;
   assign io_mon.err_sum    = r_err_sum;
   assign io_mon.wce        = r_wce;
   assign io_mon.wce_a      = r_wce_a;
   assign io_mon.wce_b      = r_wce_b;

endmodule
